// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the execute-path multiply/divide engine: widths, the
// controller's ISA opcode map, FSM state encoding and status-register bit indices.
package muldiv_unit_pkg;

    localparam int DATA_W   = 8;
    localparam int BUS_SIZE = DATA_W;
    localparam int CNT_W    = 4;
    localparam int RES_W    = 2 * DATA_W;
    localparam int ACC_W    = 2 * DATA_W + 1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_NOP  = 5'h00;
    localparam opcode_t OP_ADD  = 5'h01;
    localparam opcode_t OP_SUB  = 5'h02;
    localparam opcode_t OP_MUL  = 5'h03;
    localparam opcode_t OP_DIV  = 5'h04;
    localparam opcode_t OP_AND  = 5'h05;
    localparam opcode_t OP_OR   = 5'h06;
    localparam opcode_t OP_XOR  = 5'h07;
    localparam opcode_t OP_NOT  = 5'h08;
    localparam opcode_t OP_SHL  = 5'h09;
    localparam opcode_t OP_SHR  = 5'h0A;
    localparam opcode_t OP_LD   = 5'h0B;
    localparam opcode_t OP_ST   = 5'h0C;
    localparam opcode_t OP_JMP  = 5'h0D;
    localparam opcode_t OP_BRZ  = 5'h0E;
    localparam opcode_t OP_HALT = 5'h1F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int SR_DIV0 = 0;
    localparam int SR_Z    = 1;
    localparam int SR_T    = 2;
    localparam int SR_B    = 3;
    localparam int SR_C    = 4;
    localparam int SR_OV   = 5;

    function automatic logic is_muldiv(input opcode_t op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the CPU controller (master) and the
// multiply/divide engine (slave).
interface muldiv_unit_if;
    import muldiv_unit_pkg::*;

    logic              start;
    opcode_t           opcode;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic [DATA_W-1:0] resultLo;
    logic [DATA_W-1:0] resultHi;
    logic              busy;
    logic              done;
    logic              div0;
    logic              zero;
    logic              ovf;

    modport master (
        output start, opcode, opA, opB,
        input  resultLo, resultHi, busy, done, div0, zero, ovf
    );

    modport slave (
        input  start, opcode, opA, opB,
        output resultLo, resultHi, busy, done, div0, zero, ovf
    );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned 8x8 multiply (shift-add) and 8/8 divide (restoring),
// one bit per clock, with start/busy/done handshake and status flags.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clock,
    input  logic        nRst,
    muldiv_unit_if.slave bus
);

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               is_div_q, is_div_d;
    logic [DATA_W-1:0]  opnd_q,   opnd_d;
    logic [ACC_W-1:0]   acc_q,    acc_d;
    logic [DATA_W-1:0]  res_lo_q, res_lo_d;
    logic [DATA_W-1:0]  res_hi_q, res_hi_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic               div0_q,   div0_d;
    logic               zero_q,   zero_d;
    logic               ovf_q,    ovf_d;

    logic [DATA_W:0]    mul_sum;
    logic [ACC_W-1:0]   mul_next;
    logic [DATA_W+1:0]  div_shift;
    logic [DATA_W+1:0]  div_diff;
    logic [DATA_W:0]    div_rem;
    logic [ACC_W-1:0]   div_next;
    logic [ACC_W-1:0]   acc_step;

    // Multiply: acc = {carry, hi, multiplier}; add multiplicand on LSB, shift right.
    // Divide:   acc = {rem, quo}; shift left, trial-subtract divisor, restore on borrow.
    always_comb begin
        mul_sum   = acc_q[ACC_W-1:DATA_W] + ({1'b0, opnd_q} & {(DATA_W+1){acc_q[0]}});
        mul_next  = {1'b0, mul_sum, acc_q[DATA_W-1:1]};

        div_shift = {acc_q[ACC_W-1:DATA_W], acc_q[DATA_W-1]};
        div_diff  = div_shift - {2'b00, opnd_q};
        div_rem   = div_diff[DATA_W+1] ? div_shift[DATA_W:0] : div_diff[DATA_W:0];
        div_next  = {div_rem, acc_q[DATA_W-2:0], ~div_diff[DATA_W+1]};

        acc_step  = is_div_q ? div_next : mul_next;
    end

    // NOTE: every _d starts as its _q so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        div0_d   = div0_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && is_muldiv(bus.opcode)) begin
                    is_div_d = (bus.opcode == OP_DIV);
                    div0_d   = 1'b0;
                    zero_d   = 1'b0;
                    ovf_d    = 1'b0;
                    if (is_div_d && (bus.opB == '0)) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        res_lo_d = '1;
                        res_hi_d = bus.opA;
                        div0_d   = 1'b1;
                    end else begin
                        state_d  = ST_RUN;
                        busy_d   = 1'b1;
                        cnt_d    = CNT_LOAD;
                        opnd_d   = is_div_d ? bus.opB : bus.opA;
                        acc_d    = {{(DATA_W+1){1'b0}}, (is_div_d ? bus.opA : bus.opB)};
                    end
                end
            end

            ST_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = ST_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    res_lo_d = acc_step[DATA_W-1:0];
                    res_hi_d = acc_step[RES_W-1:DATA_W];
                    div0_d   = 1'b0;
                    zero_d   = is_div_q ? (acc_step[DATA_W-1:0] == '0)
                                        : (acc_step[RES_W-1:0] == '0);
                    ovf_d    = !is_div_q && (acc_step[RES_W-1:DATA_W] != '0);
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.resultLo = res_lo_q;
    assign bus.resultHi = res_hi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div0     = div0_q;
    assign bus.zero     = zero_q;
    assign bus.ovf      = ovf_q;

endmodule
